// File: rtl/fp_mul_param.sv
// Parameterised IEEE-754 style floating-point multiplier with a stb/ack
// handshake on each operand and on the result.
//
// Parameters: EXP_W exponent width, MAN_W stored fraction width,
//             FTZ (1 = subnormal inputs and tiny results flush to signed zero).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   input_a / input_a_stb / output_a_ack   operand A handshake
//   input_b / input_b_stb / output_b_ack   operand B handshake
//   output_z / output_z_stb / input_z_ack  product handshake
//   output_flags                   {invalid, overflow, underflow, inexact}
//
// Every operation takes the same path through UNPACK, MULT, NORM, ROUND and
// PACK, so the result strobe rises a fixed 5 edges after the B transfer.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter bit FTZ   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic                   input_a_stb,
  output logic                   output_a_ack,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   input_b_stb,
  output logic                   output_b_ack,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic                   output_z_stb,
  input  logic                   input_z_ack,
  output logic [3:0]             output_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EI = EXP_W + 8;
  localparam logic signed [EI-1:0] BIAS_S = EI'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EI-1:0] EMAX_S = EI'((1 << EXP_W) - 1);
  localparam logic signed [EI-1:0] ONE_S  = EI'(1);
  localparam logic signed [EI-1:0] PW_S   = EI'(PW);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_GET_A, S_GET_B, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_PACK, S_PUT_Z
  } state_t;

  state_t state, state_n;

  function automatic logic [EI-1:0] lzc(input logic [MAN_W-1:0] f);
    logic [EI-1:0] n;
    logic          done;
    n    = '0;
    done = 1'b0;
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (!done && !f[i]) n = n + EI'(1);
      else                done = 1'b1;
    end
    return n;
  endfunction

  function automatic logic rne_inc(input logic lsb, input logic g, input logic rest);
    return g & (rest | lsb);
  endfunction

  // Subnormals are normalised here so the multiplier always sees a leading 1.
  function automatic void unpack(input  logic [W-1:0]           x,
                                 output logic                   s,
                                 output logic signed [EI-1:0]   e,
                                 output logic [SW-1:0]          m,
                                 output logic                   zero,
                                 output logic                   inf,
                                 output logic                   nan,
                                 output logic                   snan);
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] ff;
    logic [EI-1:0]    lz;
    s    = x[W-1];
    ef   = x[W-2 -: EXP_W];
    ff   = x[MAN_W-1:0];
    nan  = (ef == '1) && (ff != '0);
    snan = nan && !ff[MAN_W-1];
    inf  = (ef == '1) && (ff == '0);
    zero = (ef == '0) && (FTZ || (ff == '0));
    lz   = lzc(ff);
    if (ef == '0) begin
      m = {1'b0, ff} << (lz + EI'(1));
      e = -BIAS_S - $signed(lz);
    end else begin
      m = {1'b1, ff};
      e = $signed(EI'(ef)) - BIAS_S;
    end
  endfunction

  // Control FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_GET_A;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    output_a_ack = 1'b0;
    output_b_ack = 1'b0;
    output_z_stb = 1'b0;
    case (state)
      S_GET_A: begin
        output_a_ack = 1'b1;
        if (input_a_stb) state_n = S_GET_B;
      end
      S_GET_B: begin
        output_b_ack = 1'b1;
        if (input_b_stb) state_n = S_UNPACK;
      end
      S_UNPACK: state_n = S_MULT;
      S_MULT:   state_n = S_NORM;
      S_NORM:   state_n = S_ROUND;
      S_ROUND:  state_n = S_PACK;
      S_PACK:   state_n = S_PUT_Z;
      S_PUT_Z: begin
        output_z_stb = 1'b1;
        if (input_z_ack) state_n = S_GET_A;
      end
      default:  state_n = S_GET_A;
    endcase
  end

  logic [W-1:0] a_reg, b_reg;

  logic                 ua_s, ub_s, ua_z, ub_z, ua_i, ub_i, ua_n, ub_n, ua_sn, ub_sn;
  logic signed [EI-1:0] ua_e, ub_e;
  logic [SW-1:0]        ua_m, ub_m;
  logic                 spec_n;
  logic [W-1:0]         spec_z_n;
  logic [3:0]           spec_f_n;

  always_comb begin
    unpack(a_reg, ua_s, ua_e, ua_m, ua_z, ua_i, ua_n, ua_sn);
    unpack(b_reg, ub_s, ub_e, ub_m, ub_z, ub_i, ub_n, ub_sn);
    spec_n   = 1'b0;
    spec_z_n = '0;
    spec_f_n = 4'b0000;
    if (ua_n || ub_n || (ua_i && ub_z) || (ub_i && ua_z)) begin
      spec_n   = 1'b1;
      spec_z_n = QNAN;
      spec_f_n = {ua_sn | ub_sn | (ua_i & ub_z) | (ub_i & ua_z), 3'b000};
    end else if (ua_i || ub_i) begin
      spec_n   = 1'b1;
      spec_z_n = {ua_s ^ ub_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ua_z || ub_z) begin
      spec_n   = 1'b1;
      spec_z_n = {ua_s ^ ub_s, {(W-1){1'b0}}};
    end
  end

  logic                 sign_p0, spec_p0;
  logic [W-1:0]         spec_z_p0;
  logic [3:0]           spec_f_p0;
  logic signed [EI-1:0] ea_p0, eb_p0;
  logic [SW-1:0]        ma_p0, mb_p0;
  logic [PW-1:0]        prod_p1;
  logic signed [EI-1:0] exp_p1;
  logic [PW-1:0]        prod_p2;
  logic signed [EI-1:0] be_p2;
  logic                 sticky_p2, tiny_p2;
  logic [MAN_W-1:0]     mant_p3;
  logic signed [EI-1:0] be_p3;
  logic                 inexact_p3, tiny_p3;

  // Normalise to a leading 1 at the top bit, then denormalise tiny results
  // so rounding lands on the subnormal grid.
  logic [PW-1:0]        pn, pd;
  logic signed [EI-1:0] en, sh, be_n;
  logic                 tiny_n, sticky_n;

  always_comb begin
    if (prod_p1[PW-1]) begin
      pn = prod_p1;
      en = exp_p1 + BIAS_S + ONE_S;
    end else begin
      pn = prod_p1 << 1;
      en = exp_p1 + BIAS_S;
    end
    tiny_n   = en[EI-1] || (en == '0);
    sh       = ONE_S - en;
    pd       = pn;
    sticky_n = 1'b0;
    be_n     = en;
    if (tiny_n) begin
      be_n = '0;
      if (sh >= PW_S) begin
        pd       = '0;
        sticky_n = |pn;
      end else begin
        pd       = pn >> sh;
        sticky_n = |(pn & ~({PW{1'b1}} << sh));
      end
    end
  end

  // A subnormal that rounds up into the hidden bit becomes the minimum normal.
  logic [SW-1:0]        mant, mant_r;
  logic [SW:0]          sum;
  logic                 g, rest, inc, inexact_r;
  logic signed [EI-1:0] be_r;

  always_comb begin
    mant      = prod_p2[PW-1 -: SW];
    g         = prod_p2[PW-SW-1];
    rest      = (|prod_p2[PW-SW-2:0]) | sticky_p2;
    inc       = rne_inc(mant[0], g, rest);
    inexact_r = g | rest;
    sum       = {1'b0, mant} + {{SW{1'b0}}, inc};
    if (sum[SW]) begin
      mant_r = sum[SW:1];
      be_r   = be_p2 + ONE_S;
    end else begin
      mant_r = sum[SW-1:0];
      be_r   = ((be_p2 == '0) && mant_r[MAN_W]) ? ONE_S : be_p2;
    end
  end

  logic [W-1:0] z_n;
  logic [3:0]   flags_n;

  always_comb begin
    z_n     = {sign_p0, be_p3[EXP_W-1:0], mant_p3};
    flags_n = {2'b00, tiny_p3 & inexact_p3, inexact_p3};
    if (spec_p0) begin
      z_n     = spec_z_p0;
      flags_n = spec_f_p0;
    end else if (FTZ && tiny_p3) begin
      z_n     = {sign_p0, {(W-1){1'b0}}};
      flags_n = 4'b0011;
    end else if (be_p3 >= EMAX_S) begin
      z_n     = {sign_p0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_n = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_GET_A && input_a_stb) a_reg <= input_a;
    if (state == S_GET_B && input_b_stb) b_reg <= input_b;
    // p0: unpacked operands and special-case result
    if (state == S_UNPACK) begin
      sign_p0   <= ua_s ^ ub_s;
      spec_p0   <= spec_n;
      spec_z_p0 <= spec_z_n;
      spec_f_p0 <= spec_f_n;
      ea_p0     <= ua_e;
      eb_p0     <= ub_e;
      ma_p0     <= ua_m;
      mb_p0     <= ub_m;
    end
    // p1: full-width significand product
    if (state == S_MULT) begin
      prod_p1 <= PW'(ma_p0) * PW'(mb_p0);
      exp_p1  <= ea_p0 + eb_p0;
    end
    // p2: normalised / denormalised product, biased exponent
    if (state == S_NORM) begin
      prod_p2   <= pd;
      be_p2     <= be_n;
      sticky_p2 <= sticky_n;
      tiny_p2   <= tiny_n;
    end
    // p3: rounded mantissa
    if (state == S_ROUND) begin
      mant_p3    <= mant_r[MAN_W-1:0];
      be_p3      <= be_r;
      inexact_p3 <= inexact_r;
      tiny_p3    <= tiny_p2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_z     <= '0;
      output_flags <= 4'b0000;
    end else if (state == S_PACK) begin
      output_z     <= z_n;
      output_flags <= flags_n;
    end
  end
endmodule

// File: doc/fp_mul_param.md
FP_MUL_PARAM -- requirements
Module: fp_mul_param

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 5..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 10..52); W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter FTZ, default 0; 1 = flush subnormal inputs and tiny results to signed zero.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 input_a  input  W  operand A.
REQ-007 input_a_stb  input  1  A valid.
REQ-008 output_a_ack  output  1  ready for A.
REQ-009 input_b  input  W  operand B.
REQ-010 input_b_stb  input  1  B valid.
REQ-011 output_b_ack  output  1  ready for B.
REQ-012 output_z  output  W  product.
REQ-013 output_z_stb  output  1  product valid.
REQ-014 input_z_ack  input  1  consumer accepted product.
REQ-015 output_flags  output  4  {invalid, overflow, underflow, inexact}, valid with output_z_stb.

Function
REQ-016 SHALL sequence through states GET_A, GET_B, UNPACK, MULT, NORM, ROUND, PACK, PUT_Z, one state per cycle except GET_A/GET_B/PUT_Z.
REQ-017 output_a_ack SHALL be high only in GET_A; A transfers on an edge with output_a_ack and input_a_stb both high; state then moves to GET_B.
REQ-018 output_b_ack SHALL be high only in GET_B; B transfers on an edge with both high; B is never accepted before A.
REQ-019 After the B transfer edge, output_z_stb SHALL rise after exactly 5 further rising edges, independent of operand values (fixed latency, including subnormals and specials).
REQ-020 In PUT_Z, output_z and output_flags SHALL remain stable until input_z_ack is sampled high; the next state is then GET_A with output_z_stb low.
REQ-021 If input_z_ack is high in a cycle where output_z_stb is low, it SHALL be ignored.
REQ-022 Bias = 2^(EXP_W-1)-1; significand product SHALL be computed at full 2*(MAN_W+1) width, no truncation before rounding.
REQ-023 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits; a mantissa carry-out SHALL increment the exponent.
REQ-024 Result sign SHALL be sign(A) xor sign(B) for all non-NaN results.
REQ-025 Any NaN operand, or inf*0, SHALL produce canonical quiet NaN {0, all-ones exponent, MSB fraction 1, rest 0}; invalid set for inf*0 and signalling NaN inputs.
REQ-026 inf*finite-nonzero SHALL yield signed infinity, no flags.
REQ-027 zero*finite SHALL yield signed zero, no flags.
REQ-028 Exponent above max after rounding SHALL yield signed infinity with overflow and inexact set.
REQ-029 With FTZ=0, subnormal inputs SHALL be normalised via leading-zero count; tiny results SHALL be denormalised then RNE-rounded; underflow set only if tiny and inexact.
REQ-030 With FTZ=1, subnormal inputs SHALL be treated as zero and tiny results SHALL become signed zero with underflow and inexact set.
REQ-031 inexact SHALL be set whenever rounding discards a nonzero bit.

Reset
REQ-032 While rst is high at an edge, state SHALL go to GET_A; output_a_ack 1 and output_b_ack, output_z_stb, output_z, output_flags 0 after that edge.
REQ-033 Reset asserted in any state, including mid-computation or PUT_Z, SHALL discard the in-flight operation; no output_z_stb pulse for it.

Verification (defaults EXP_W=8, MAN_W=23, FTZ=0)
REQ-034 A=0x3F800000, B=0x40000000 -> output_z=0x40000000, flags 0, stb exactly 5 edges after B transfer; 0x40400000*0x40800000 -> 0x41400000.
REQ-035 0x7F800000*0x00000000 -> 0x7FC00000, invalid=1; 0x7F800000*0x3F800000 -> 0x7F800000, flags 0; 0x80000000*0x3F800000 -> 0x80000000.
REQ-036 0x7F7FFFFF*0x40000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000*0x3F000000 -> 0x00400000, flags 0; 0x00000001*0x3F000000 -> 0x00000000, underflow=1, inexact=1.
REQ-037 Hold input_z_ack low 10 cycles in PUT_Z -> output_z/flags/stb unchanged; ack pulse -> stb low next cycle, output_a_ack high.
REQ-038 Assert rst for 1 cycle in MULT -> no stb for that operation; following 0x3F800000*0x3F800000 -> 0x3F800000.
REQ-039 Rerun REQ-034/035 with EXP_W=5, MAN_W=10: 0x3C00*0x4000 -> 0x4000; with FTZ=1, 0x0001*0x3C00 -> 0x0000.
